// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared FSM encoding, mode codes and default divisors
package counter_ctrl_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;
   localparam logic [1:0] MODE_FREE = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_PP   = 2'b10;
   localparam logic [1:0] MODE_DOWN = 2'b11;
   localparam int DIV_SLOW_DEF = 50000000;
   localparam int DIV_FAST_DEF = 5000000;
endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// tick_gen: 26-bit prescaler that flags its terminal cycle
//   clk50m   - clock
//   enable   - advance the prescaler this cycle
//   clear    - synchronous clear to 0 (wins over enable)
//   div      - cycles per terminal
//   terminal - high in the cycle where the count has reached div-1 or beyond
module tick_gen (
   input  logic        clk50m,
   input  logic        enable,
   input  logic        clear,
   input  logic [25:0] div,
   output logic        terminal
);
   logic [25:0] cnt;
   // ">=" keeps a run terminating even if div shrinks below the current count
   assign terminal = enable && (cnt >= div - 26'd1);
   always_ff @(posedge clk50m) begin
      if (clear) cnt <= '0;
      else if (enable) cnt <= terminal ? '0 : cnt + 26'd1;
   end
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause controller that paces an external up/down counter
//   clk50m, reset        - clock, synchronous active-high reset
//   start, stop          - single-cycle command pulses (stop wins when both are high)
//   speed                - selects DIV_FAST (1) or DIV_SLOW (0)
//   mode, limit          - run mode and terminal count, captured when a run is loaded
//   count                - counter value fed back from the datapath
//   tick, UD, load, load_val - counter step enable, direction and preset
//   SS, busy, done       - running, active and completion indications
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int DIV_SLOW = DIV_SLOW_DEF,
   parameter int DIV_FAST = DIV_FAST_DEF
) (
   input  logic       clk50m,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       speed,
   input  logic [1:0] mode,
   input  logic [7:0] limit,
   input  logic [7:0] count,
   output logic       tick,
   output logic       UD,
   output logic       SS,
   output logic       load,
   output logic [7:0] load_val,
   output logic       busy,
   output logic       done
);
   logic [1:0]  state;
   logic [1:0]  mode_r;
   logic [7:0]  limit_r;
   logic [25:0] div;
   logic        term;
   logic        finish;
   logic        bounce;
   assign div = speed ? 26'(DIV_FAST) : 26'(DIV_SLOW);
   tick_gen u_tick_gen (
      .clk50m  (clk50m),
      .enable  (state == S_RUN && !stop),
      .clear   (reset || state == S_LOAD),
      .div     (div),
      .terminal(term)
   );
   // one-shot completion and ping-pong turnaround replace the tick on a terminal
   assign finish = (mode_r == MODE_UP && count == limit_r) || (mode_r == MODE_DOWN && count == 8'd0);
   assign bounce = mode_r == MODE_PP && (UD ? count == limit_r : count == 8'd0);
   always_ff @(posedge clk50m) begin
      if (reset) begin
         state    <= S_IDLE;
         mode_r   <= MODE_FREE;
         limit_r  <= '0;
         tick     <= 1'b0;
         UD       <= 1'b1;
         SS       <= 1'b0;
         load     <= 1'b0;
         load_val <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         tick <= 1'b0;
         load <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE:
               if (start && !stop) begin
                  state    <= S_LOAD;
                  mode_r   <= mode;
                  limit_r  <= limit;
                  load     <= 1'b1;
                  load_val <= mode == MODE_DOWN ? limit : 8'd0;
                  UD       <= mode != MODE_DOWN;
                  busy     <= 1'b1;
               end
            S_LOAD: begin
               state <= S_RUN;
               SS    <= 1'b1;
            end
            S_RUN:
               if (stop) begin
                  state <= S_PAUSE;
                  SS    <= 1'b0;
               end else if (term) begin
                  if (finish) begin
                     state <= S_IDLE;
                     SS    <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (bounce) UD <= !UD;
                  else tick <= 1'b1;
               end
            S_PAUSE:
               if (stop) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (start) begin
                  state <= S_RUN;
                  SS    <= 1'b1;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: randomized and directed checks of counter_ctrl against a behavioural model
module tb_counter_ctrl;
   logic       clk50m = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       speed = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] limit = 8'd0;
   logic [7:0] count = 8'd0;
   logic       tick, UD, SS, load, busy, done;
   logic [7:0] load_val;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk50m = ~clk50m;
   counter_ctrl #(.DIV_SLOW(4), .DIV_FAST(2)) dut (
      .clk50m(clk50m), .reset(reset), .start(start), .stop(stop), .speed(speed),
      .mode(mode), .limit(limit), .count(count), .tick(tick), .UD(UD), .SS(SS),
      .load(load), .load_val(load_val), .busy(busy), .done(done)
   );
   always @(posedge clk50m) begin
      if (load) count <= load_val;
      else if (tick) count <= UD ? count + 8'd1 : count - 8'd1;
   end
   typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSE} mst_t;
   mst_t ms = M_IDLE;
   int  elapsed = 0;
   int  m_mode = 0;
   int  m_limit = 0;
   int  e_lv = 0;
   bit  e_tick = 0, e_ud = 1, e_load = 0, e_done = 0;
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: observed %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask
   task automatic model_step();
      int div;
      bit hit;
      e_tick = 0;
      e_load = 0;
      e_done = 0;
      if (reset) begin
         ms = M_IDLE;
         elapsed = 0;
         m_mode = 0;
         m_limit = 0;
         e_lv = 0;
         e_ud = 1;
      end else if (ms == M_IDLE) begin
         if (start && !stop) begin
            ms = M_LOAD;
            m_mode = int'(mode);
            m_limit = int'(limit);
            e_load = 1;
            e_lv = mode == 2'b11 ? int'(limit) : 0;
            e_ud = mode != 2'b11;
         end
      end else if (ms == M_LOAD) begin
         ms = M_RUN;
         elapsed = 0;
      end else if (ms == M_RUN) begin
         if (stop) ms = M_PAUSE;
         else begin
            div = speed ? 2 : 4;
            if (elapsed + 1 >= div) begin
               elapsed = 0;
               if (m_mode == 0) e_tick = 1;
               else if (m_mode == 2) begin
                  hit = e_ud ? int'(count) == m_limit : count == 8'd0;
                  if (hit) e_ud = !e_ud;
                  else e_tick = 1;
               end else begin
                  hit = m_mode == 1 ? int'(count) == m_limit : count == 8'd0;
                  if (hit) begin
                     e_done = 1;
                     ms = M_IDLE;
                  end else e_tick = 1;
               end
            end else elapsed++;
         end
      end else begin
         if (stop) ms = M_IDLE;
         else if (start) ms = M_RUN;
      end
   endtask
   task automatic step(input bit st, input bit sp, input bit rs);
      start = st;
      stop = sp;
      reset = rs;
      model_step();
      @(posedge clk50m);
      @(negedge clk50m);
      check("tick", tick, e_tick);
      check("UD", UD, e_ud);
      check("SS", SS, ms == M_RUN);
      check("load", load, e_load);
      check("load_val", load_val, e_lv);
      check("busy", busy, ms != M_IDLE);
      check("done", done, e_done);
      start = 0;
      stop = 0;
      reset = 0;
   endtask
   task automatic run_until_done(input int budget, output int n, output int ticks);
      n = -1;
      ticks = 0;
      for (int i = 1; i <= budget; i++) begin
         step(0, 0, 0);
         ticks += int'(tick);
         if (done) begin
            n = i;
            break;
         end
      end
   endtask
   initial begin
      int n, ticks, k;
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);
      mode = 2'b00; limit = 8'd9; speed = 1'b0;
      step(1, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0);
      step(0, 0, 1);
      check("rst_midrun_UD", UD, 1);
      check("rst_midrun_SS", SS, 0);
      check("rst_midrun_busy", busy, 0);
      mode = 2'b01; limit = 8'd3; speed = 1'b0;
      step(1, 0, 0);
      check("up_load", load, 1);
      check("up_load_val", load_val, 0);
      mode = 2'b10; limit = 8'd7;
      run_until_done(60, n, ticks);
      check("up_done_cycle", n, 17);
      check("up_ticks", ticks, 3);
      check("up_count", count, 3);
      step(0, 0, 0);
      check("up_after_SS", SS, 0);
      mode = 2'b11; limit = 8'd5; speed = 1'b0;
      step(1, 0, 0);
      check("down_load_val", load_val, 5);
      check("down_UD", UD, 0);
      run_until_done(80, n, ticks);
      check("down_done_cycle", n, 25);
      check("down_ticks", ticks, 5);
      check("down_count", count, 0);
      mode = 2'b00; speed = 1'b0;
      step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      step(0, 1, 0);
      check("pause_SS", SS, 0);
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         ticks += int'(tick);
      end
      check("pause_ticks", ticks, 0);
      step(1, 0, 0);
      k = -1;
      for (int i = 1; i <= 20; i++) begin
         step(0, 0, 0);
         if (tick) begin
            k = i;
            break;
         end
      end
      check("resume_tick_delay", k, 2);
      step(1, 1, 0);
      check("both_run_SS", SS, 0);
      check("both_run_busy", busy, 1);
      step(1, 1, 0);
      check("both_pause_busy", busy, 0);
      check("both_pause_done", done, 0);
      step(1, 1, 0);
      check("both_idle_busy", busy, 0);
      mode = 2'b10; limit = 8'd0; speed = 1'b1;
      step(1, 0, 0);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0);
         ticks += int'(tick);
      end
      check("pp_limit0_ticks", ticks, 0);
      step(0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            mode = 2'($urandom_range(0, 3));
            limit = 8'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 15) == 0) speed = !speed;
         step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 399) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter DIV_SLOW, default 50000000: clk50m cycles per tick when speed=0.
REQ-002 Parameter DIV_FAST, default 5000000: clk50m cycles per tick when speed=1.
REQ-003 The block SHALL have one clock, clk50m; reset is synchronous and active-high, port name reset.
REQ-004 Ports, in this order:
- clk50m in 1: system clock.
- reset in 1: synchronous active-high reset.
- start in 1: single-cycle pulse to start or resume.
- stop in 1: single-cycle pulse to pause or abort.
- speed in 1: 0 selects slow, 1 selects fast.
- mode in 2: 00 free-run, 01 one-shot up, 10 ping-pong, 11 one-shot down.
- limit in 8: terminal count.
- count in 8: counter value fed back from the counter datapath.
- tick out 1: one-cycle step enable to the counter.
- UD out 1: direction, 1=up.
- SS out 1: run indicator, 1=running.
- load out 1: one-cycle preset strobe.
- load_val out 8: preset value.
- busy out 1: high in LOAD, RUN and PAUSE.
- done out 1: one-cycle completion pulse.

Function
REQ-005 FSM states: IDLE, LOAD, RUN, PAUSE.
REQ-006 IDLE: SS=0, tick=0.
- start → LOAD.
- stop ignored.
REQ-007 LOAD lasts exactly one cycle, then → RUN. During LOAD:
- load=1.
- mode and limit are registered; changes after LOAD are ignored until the next LOAD.
- load_val=limit if mode=11, else 0.
- UD=0 if mode=11, else 1.
- Prescaler cleared to 0.
REQ-008 RUN: SS=1; prescaler increments every cycle.
- Terminal cycle: prescaler >= DIV-1, where DIV is chosen by the current speed.
- On the terminal cycle the prescaler returns to 0.
- A speed change mid-run takes effect immediately; ">=" guarantees termination.
REQ-009 First terminal cycle occurs DIV cycles after RUN entry; terminals then repeat every DIV cycles.
REQ-010 Terminal-cycle action by registered mode. Exactly one outcome per terminal:
- 00: tick=1; the counter wraps 255↔0 itself.
- 01: if count==limit: done=1, tick=0, → IDLE; else tick=1.
- 11: if count==0: done=1, tick=0, → IDLE; else tick=1.
- 10, UD=1 and count==limit: UD←0, tick=0.
- 10, UD=0 and count==0: UD←1, tick=0.
- 10, otherwise: tick=1.
REQ-011 Ping-pong with limit=0: UD toggles on every terminal and tick is never asserted.
REQ-012 One-shot with the terminal condition already true at RUN entry: done on the first terminal, with no tick.
REQ-013 RUN with stop=1 → PAUSE.
- stop has priority over that cycle's terminal action: no tick, no done, no UD change.
- Prescaler holds its value.
REQ-014 PAUSE: SS=0, tick=0, prescaler frozen.
- start → RUN; the prescaler resumes from its held value.
- stop → IDLE (abort, no done).
REQ-015 Simultaneous start and stop: stop wins in every state.
REQ-016 All outputs SHALL be registered; tick, load and done are never high for two consecutive cycles.

Reset
REQ-017 When reset=1 on a clk50m edge, the next cycle SHALL show:
- state=IDLE, prescaler=0.
- tick=0, SS=0, load=0, load_val=0, busy=0, done=0, UD=1.
- Registered mode=00, registered limit=0.
REQ-018 Reset overrides every other input in every state, including mid-RUN and mid-LOAD.

Structure
REQ-019 Package counter_ctrl_pkg SHALL hold:
- FSM state encoding.
- Mode constants MODE_FREE, MODE_UP, MODE_PP, MODE_DOWN.
- Default divisor constants.
REQ-020 The prescaler SHALL be a sub-module tick_gen:
- Inputs: enable, clear, div.
- Output: terminal pulse.
- 26-bit internal counter.
REQ-021 counter_ctrl SHALL contain only the FSM, the direction register and the output registers.

Verification
Bench settings: DIV_SLOW=4, DIV_FAST=2. The bench uses a behavioural counter: load sets count to load_val; tick steps count in the UD direction.
REQ-022 Mode 01, limit=3, speed=0, start → load one cycle with load_val=0; ticks at RUN cycles 4, 8, 12; count=3; done at cycle 16; then SS=0, busy=0.
REQ-023 Mode 10, limit=2, speed=1 → count sequence 0,1,2; one silent period with UD→0; then 1,0; one silent period with UD→1; repeats.
REQ-024 Mode 00, speed=0, stop at RUN cycle 2 → SS=0, no ticks for 10 cycles; start → next tick exactly 2 cycles after resume.
REQ-025 start and stop in the same cycle:
- In RUN → PAUSE.
- In IDLE → stays IDLE.
- In PAUSE → IDLE, done=0.
REQ-026 Mode 11, limit=5 → load_val=5, UD=0; five ticks to count=0; done on the sixth terminal.
REQ-027 reset mid-RUN → next cycle all outputs at their REQ-017 values; a later start behaves as from power-up.
